inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'hbfc0_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset; synchronous, active-high.
REQ-004 inst_req  output  1  sram-like fetch request to the AXI bridge.
REQ-005 inst_wr  output  1  write flag; SHALL be constant 0.
REQ-006 inst_size  output  2  access size; SHALL be constant 2'b10 (word).
REQ-007 inst_addr  output  32  fetch address.
REQ-008 inst_wdata  output  32  write data; SHALL be constant 0.
REQ-009 inst_rdata  input  32  returned instruction word.
REQ-010 inst_addr_ok  input  1  bridge accepted the request.
REQ-011 inst_data_ok  input  1  inst_rdata valid this cycle.
REQ-012 br_valid  input  1  one-cycle redirect pulse from execute.
REQ-013 br_target  input  32  redirect address, valid with br_valid.
REQ-014 ds_allowin  input  1  decode can accept an instruction this cycle.
REQ-015 fs_to_ds_valid  output  1  fs_pc/fs_inst/fs_adel valid to decode.
REQ-016 fs_pc  output  32  PC of the presented instruction.
REQ-017 fs_inst  output  32  presented instruction word.
REQ-018 fs_adel  output  1  presented PC misaligned; fs_inst SHALL be 0 when set.

Function
REQ-019 States SHALL be IDLE, REQ, WAIT, HOLD; at most one request SHALL be outstanding.
REQ-020 IDLE: SHALL move to REQ next cycle with pc = RESET_PC.
REQ-021 REQ: inst_req = 1, inst_addr = pc; both SHALL stay stable until the cycle inst_addr_ok = 1, then the state SHALL become WAIT.
REQ-022 REQ with pc[1:0] != 0: inst_req SHALL stay 0; the state SHALL go to HOLD with fs_adel = 1 and fs_inst = 0.
REQ-023 WAIT: when inst_data_ok = 1, inst_rdata SHALL be registered into fs_inst and the state SHALL become HOLD; fs_to_ds_valid SHALL rise the next cycle (1-cycle latency).
REQ-024 HOLD: fs_to_ds_valid = 1; when ds_allowin = 1, the state SHALL become REQ with pc = pc + 4 (mod 2^32), or pc = pending target if a redirect is pending.
REQ-025 inst_data_ok in IDLE, REQ or HOLD SHALL be ignored.
REQ-026 Redirect in HOLD: the held instruction SHALL be dropped (fs_to_ds_valid = 0 next cycle), and the state SHALL become REQ with pc = br_target.
REQ-027 Redirect in REQ before addr_ok: br_target SHALL be latched as pending; the current address SHALL keep being held until addr_ok, then the state SHALL become WAIT with a cancel flag set.
REQ-028 Redirect in REQ in the same cycle as inst_addr_ok: the state SHALL become WAIT with cancel set and br_target pending.
REQ-029 Redirect in WAIT, or cancel set when data_ok arrives: the returned word SHALL be discarded, cancel cleared, and the state SHALL become REQ with pc = pending target.
REQ-030 br_valid in the same cycle as inst_data_ok in WAIT: the data SHALL be discarded, and the state SHALL become REQ with pc = br_target.
REQ-031 A second br_valid while a target is pending SHALL overwrite it (latest wins).

Reset
REQ-032 While reset = 1:
- state SHALL be IDLE; inst_req, fs_to_ds_valid, fs_adel and cancel SHALL be 0.
- inst_addr, fs_pc and fs_inst SHALL be 0; the pending target SHALL be invalid.
REQ-033 Reset mid-transaction SHALL abandon the outstanding request; the bridge is reset by the same signal.

Structure
REQ-034 A shared package SHALL hold the state encoding, RESET_PC default, SIZE_WORD = 2'b10 and the sram-like bundle constants.
REQ-035 The block SHALL be a single module with no sub-module; the redirect/cancel logic is a small register pair inside it.

Verification
REQ-036 Reset release, addr_ok 2 cycles after req, data_ok 3 cycles later with rdata 32'h2408_0001, ds_allowin = 1 -> fs_pc = bfc00000, fs_inst = 24080001; next inst_addr = bfc00004.
REQ-037 ds_allowin held 0 for 5 cycles in HOLD -> fs_to_ds_valid and fs_inst stable, inst_req = 0 throughout.
REQ-038 br_valid with target 32'hbfc0_0100 while in WAIT -> the data_ok word is dropped; next inst_addr = bfc00100, and no instruction is presented for the old PC.
REQ-039 br_valid in the same cycle as addr_ok, followed by a second br_valid with target bfc00200 -> the response is discarded, and the next request goes to bfc00200.
REQ-040 br_target = 32'hbfc0_0102 -> no inst_req is issued; fs_adel = 1, fs_inst = 0, fs_pc = bfc00102.
REQ-041 reset asserted during WAIT, then a stray inst_data_ok -> ignored; the first request after reset is to bfc00000.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding, reset PC
// and the constant fields of the sram-like fetch bundle.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fs_state_e;

  localparam logic [31:0] RESET_PC_DEF    = 32'hbfc0_0000;
  localparam logic [1:0]  SIZE_WORD       = 2'b10;
  localparam logic        INST_WR_READ    = 1'b0;
  localparam logic [31:0] INST_WDATA_NONE = 32'h0000_0000;
  localparam logic [31:0] PC_STEP         = 32'd4;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding sram-like read at a time, with
// branch redirects either applied immediately or deferred via pending/cancel.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic [31:0] inst_rdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_adel
);

  fs_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        adel_q, adel_d;
  logic        vld_q, vld_d;
  logic        req_q, req_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        cancel_q, cancel_d;

  logic        go_req;
  logic [31:0] new_pc;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    adel_d     = adel_q;
    vld_d      = vld_q;
    req_d      = req_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    cancel_d   = cancel_q;
    go_req     = 1'b0;
    new_pc     = pc_q;

    case (state_q)
      S_IDLE: begin
        go_req = 1'b1;
        new_pc = RESET_PC;
      end
      S_REQ: begin
        if (pc_misaligned(pc_q)) begin
          // A misaligned PC never reaches the bridge; it is presented as an exception.
          if (br_valid) begin
            go_req = 1'b1;
            new_pc = br_target;
          end else begin
            state_d = S_HOLD;
            adel_d  = 1'b1;
            inst_d  = '0;
            vld_d   = 1'b1;
          end
        end else begin
          if (br_valid) begin
            pend_d     = 1'b1;
            pend_tgt_d = br_target;
          end
          if (inst_addr_ok) begin
            state_d  = S_WAIT;
            req_d    = 1'b0;
            cancel_d = pend_q | br_valid;
          end
        end
      end
      S_WAIT: begin
        if (br_valid) begin
          pend_d     = 1'b1;
          pend_tgt_d = br_target;
          cancel_d   = 1'b1;
        end
        if (inst_data_ok) begin
          if (br_valid) begin
            go_req = 1'b1;
            new_pc = br_target;
          end else if (cancel_q) begin
            go_req = 1'b1;
            new_pc = pend_tgt_q;
          end else begin
            state_d = S_HOLD;
            inst_d  = inst_rdata;
            adel_d  = 1'b0;
            vld_d   = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (br_valid) begin
          go_req = 1'b1;
          new_pc = br_target;
        end else if (ds_allowin) begin
          go_req = 1'b1;
          new_pc = pend_q ? pend_tgt_q : pc_q + PC_STEP;
        end
      end
    endcase

    // Every path into REQ clears the presented slot and any deferred redirect.
    if (go_req) begin
      state_d  = S_REQ;
      pc_d     = new_pc;
      req_d    = !pc_misaligned(new_pc);
      vld_d    = 1'b0;
      adel_d   = 1'b0;
      pend_d   = 1'b0;
      cancel_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      inst_q     <= '0;
      adel_q     <= 1'b0;
      vld_q      <= 1'b0;
      req_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      cancel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      adel_q     <= adel_d;
      vld_q      <= vld_d;
      req_q      <= req_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      cancel_q   <= cancel_d;
    end
  end

  assign inst_req       = req_q;
  assign inst_wr        = INST_WR_READ;
  assign inst_size      = SIZE_WORD;
  assign inst_addr      = pc_q;
  assign inst_wdata     = INST_WDATA_NONE;
  assign fs_to_ds_valid = vld_q;
  assign fs_pc          = pc_q;
  assign fs_inst        = inst_q;
  assign fs_adel        = adel_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a bridge model plus a transaction-level fetch model
// (next address = latest redirect target, else previous fetch + 4).
module tb_inst_fetch;
  localparam logic [31:0] RST_PC = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [31:0] inst_rdata = '0;
  logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        ds_allowin = 1'b0;
  logic        fs_to_ds_valid, fs_adel;
  logic [31:0] fs_pc, fs_inst;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .br_valid(br_valid), .br_target(br_target), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc), .fs_inst(fs_inst), .fs_adel(fs_adel)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RST_PC) return 32'h2408_0001;
    return (a * 32'h9e37_79b1) ^ 32'h1357_9bdf;
  endfunction

  // Stimulus knobs
  bit          rst_s = 1'b1, br_s = 1'b0, allow_s = 1'b1, stray_s = 1'b0;
  bit          br_aok_s = 1'b0, rand_mode = 1'b0;
  logic [31:0] tgt_s = '0;
  int          a_cfg = -1, d_cfg = -1;

  // Bridge model
  bit          out_q = 1'b0;
  logic [31:0] out_addr = '0;
  int          acnt = 0, dcnt = 0;

  // Fetch reference model
  bit          m_rst = 1'b1, m_idle = 1'b1, m_req = 1'b0, m_show = 1'b0;
  bit          m_adel_wait = 1'b0, m_br_since = 1'b0;
  logic [31:0] m_next = RST_PC, m_cur = '0;

  logic        s_req, s_vld, s_adel;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic int new_alat();
    return (a_cfg < 0) ? int'($urandom_range(0, 2)) : a_cfg;
  endfunction

  function automatic int new_dcnt();
    return ((d_cfg < 0) ? int'($urandom_range(1, 4)) : d_cfg) - 1;
  endfunction

  task automatic step();
    bit aok, dok, brv, dok_real, start, allow;
    logic [31:0] rd;
    @(negedge clk);
    s_req = inst_req; s_vld = fs_to_ds_valid; s_adel = fs_adel;
    s_addr = inst_addr; s_pc = fs_pc; s_inst = fs_inst;

    if (m_rst) begin
      chk("rst_addr", s_addr, 32'h0);
      chk("rst_pc", s_pc, 32'h0);
      chk("rst_inst", s_inst, 32'h0);
    end
    chk("req", 32'(s_req), 32'(m_req));
    if (m_req) chk("addr", s_addr, m_cur);
    chk("vld", 32'(s_vld), 32'(m_show));
    if (m_show) begin
      chk("pc", s_pc, m_cur);
      chk("adel", 32'(s_adel), 32'(m_cur[1:0] != 2'b00));
      chk("inst", s_inst, (m_cur[1:0] != 2'b00) ? 32'h0 : mem_word(m_cur));
    end else begin
      chk("adel_off", 32'(s_adel), 32'h0);
    end
    chk("wr", 32'(inst_wr), 32'h0);
    chk("size", 32'(inst_size), 32'h2);
    chk("wdata", inst_wdata, 32'h0);

    aok = 1'b0; dok = 1'b0; rd = $urandom;
    if (!rst_s) begin
      if (s_req && !out_q) begin
        if (acnt == 0) aok = 1'b1; else acnt--;
      end
      if (out_q) begin
        if (dcnt == 0) begin dok = 1'b1; rd = mem_word(out_addr); end
        else dcnt--;
      end else if (stray_s || (rand_mode && $urandom_range(0, 7) == 0)) begin
        dok = 1'b1;
      end
    end
    if (rand_mode) tgt_s = {16'hbfc0, 14'($urandom), 2'b00};
    brv = !rst_s && !m_idle &&
          (br_s || (br_aok_s && aok) || (rand_mode && $urandom_range(0, 11) == 0));
    allow = rand_mode ? ($urandom_range(0, 9) < 7) : allow_s;

    reset = rst_s; inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd;
    br_valid = brv; br_target = tgt_s; ds_allowin = allow;

    dok_real = dok && out_q;
    if (rst_s) begin
      out_q = 1'b0;
      acnt = new_alat();
    end else begin
      if (dok_real) out_q = 1'b0;
      if (aok) begin
        out_q = 1'b1; out_addr = s_addr; dcnt = new_dcnt(); acnt = new_alat();
      end
    end

    start = 1'b0;
    if (rst_s) begin
      m_rst = 1'b1; m_idle = 1'b1; m_req = 1'b0; m_show = 1'b0;
      m_adel_wait = 1'b0; m_br_since = 1'b0; m_next = RST_PC;
    end else begin
      m_rst = 1'b0;
      if (m_idle) begin m_idle = 1'b0; start = 1'b1; end
      if (brv) begin m_next = tgt_s; m_br_since = 1'b1; end
      if (m_req && aok) m_req = 1'b0;
      if (dok_real) begin
        if (m_br_since) start = 1'b1; else m_show = 1'b1;
      end else if (m_show && (brv || allow)) begin
        m_show = 1'b0; start = 1'b1;
      end
      if (m_adel_wait) begin
        m_adel_wait = 1'b0;
        if (brv) start = 1'b1; else m_show = 1'b1;
      end
      if (start) begin
        m_cur = m_next; m_next = m_next + 32'd4; m_br_since = 1'b0;
        m_req = (m_cur[1:0] == 2'b00); m_adel_wait = !m_req;
      end
    end
  endtask

  task automatic wait_vld(input int lim);
    int n = 0;
    step();
    while (!s_vld && n < lim) begin step(); n++; end
    chk("wait_vld", 32'(s_vld), 32'h1);
  endtask

  task automatic wait_req(input int lim);
    int n = 0;
    step();
    while (!s_req && n < lim) begin step(); n++; end
    chk("wait_req", 32'(s_req), 32'h1);
  endtask

  task automatic wait_out(input int lim);
    int n = 0;
    while (!out_q && n < lim) begin step(); n++; end
    chk("wait_out", 32'(out_q), 32'h1);
  endtask

  initial begin
    logic [31:0] held;
    a_cfg = 2; d_cfg = 3; allow_s = 1'b1;
    rst_s = 1'b1; repeat (3) step();
    rst_s = 1'b0;

    // First fetch after reset, then sequential next address
    wait_vld(20);
    chk("t1_pc", s_pc, 32'hbfc0_0000);
    chk("t1_inst", s_inst, 32'h2408_0001);
    wait_req(20);
    chk("t1_next", s_addr, 32'hbfc0_0004);

    // Decode stalled for 5 cycles in HOLD
    allow_s = 1'b0;
    wait_vld(20);
    held = s_inst;
    repeat (5) begin
      step();
      chk("t2_vld", 32'(s_vld), 32'h1);
      chk("t2_inst", s_inst, held);
      chk("t2_req", 32'(s_req), 32'h0);
    end
    d_cfg = 4; allow_s = 1'b1;

    // Redirect while waiting for data
    wait_out(20);
    br_s = 1'b1; tgt_s = 32'hbfc0_0100; step(); br_s = 1'b0;
    wait_req(20);
    chk("t3_addr", s_addr, 32'hbfc0_0100);
    a_cfg = 0;

    // Redirect with addr_ok, then a second redirect wins
    wait_vld(20);
    br_aok_s = 1'b1; tgt_s = 32'hbfc0_0180;
    wait_out(20);
    br_aok_s = 1'b0;
    br_s = 1'b1; tgt_s = 32'hbfc0_0200; step(); br_s = 1'b0;
    wait_req(20);
    chk("t4_addr", s_addr, 32'hbfc0_0200);

    // Misaligned redirect target
    allow_s = 1'b0;
    wait_vld(20);
    br_s = 1'b1; tgt_s = 32'hbfc0_0102; step(); br_s = 1'b0;
    wait_vld(20);
    chk("t5_adel", 32'(s_adel), 32'h1);
    chk("t5_inst", s_inst, 32'h0);
    chk("t5_pc", s_pc, 32'hbfc0_0102);
    chk("t5_req", 32'(s_req), 32'h0);
    br_s = 1'b1; tgt_s = 32'hbfc0_0300; step(); br_s = 1'b0;
    allow_s = 1'b1;

    // Reset in WAIT, then a stray data_ok
    wait_out(20);
    a_cfg = 2;
    rst_s = 1'b1; repeat (2) step(); rst_s = 1'b0;
    stray_s = 1'b1; step(); step(); stray_s = 1'b0;
    wait_req(20);
    chk("t6_addr", s_addr, RST_PC);

    // Randomized traffic
    a_cfg = -1; d_cfg = -1; rand_mode = 1'b1;
    repeat (3000) begin
      rst_s = ($urandom_range(0, 599) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
